// File: rtl/bib_pkg.sv
// rtl/bib_pkg.sv - shared opcodes and FSM state type for the serial ALU
package bib_pkg;

   localparam logic [2:0] OP_TOPLA    = 3'b000;
   localparam logic [2:0] OP_CIKAR    = 3'b001;
   localparam logic [2:0] OP_VE       = 3'b010;
   localparam logic [2:0] OP_VEYA     = 3'b011;
   localparam logic [2:0] OP_KOMSU    = 3'b100;
   localparam logic [2:0] OP_HERHANGI = 3'b101;
   localparam logic [2:0] OP_CIFT     = 3'b110;
   localparam logic [2:0] OP_TEK      = 3'b111;

   typedef enum logic {
      BOS  = 1'b0,
      ISLE = 1'b1
   } durum_t;

endpackage

// File: rtl/bib_tarayici.sv
// rtl/bib_tarayici.sv - bit-serial scanner over the 2W-bit operand field
// One bit per enabled edge; flags fold in the current bit so the result is valid on the last edge.
module bib_tarayici
   import bib_pkg::*;
#(
   parameter int W = 3
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           run,
   input  logic [2*W-1:0] alan,
   input  logic [2:0]     opkod,
   output logic           son,
   output logic           bayrak
);

   localparam int N  = 2 * W;
   localparam int CW = $clog2(N);

   logic [CW-1:0] say_q, say_d;
   logic          onceki_q, onceki_d;
   logic          herhangi_q, herhangi_d;
   logic          parite_q, parite_d;
   logic          komsu_q, komsu_d;

   logic bit_c;
   logic herhangi_n, parite_n, komsu_n;

   assign bit_c = alan[say_q];

   always_comb begin
      say_d      = say_q;
      onceki_d   = onceki_q;
      herhangi_d = herhangi_q;
      parite_d   = parite_q;
      komsu_d    = komsu_q;

      // Bit 0 only seeds the previous-bit register; pairs start at index 1.
      herhangi_n = herhangi_q | bit_c;
      parite_n   = parite_q ^ bit_c;
      komsu_n    = komsu_q | ((say_q != '0) && (bit_c == onceki_q));

      son = run && (say_q == CW'(N - 1));

      if (start) begin
         say_d      = '0;
         onceki_d   = 1'b0;
         herhangi_d = 1'b0;
         parite_d   = 1'b0;
         komsu_d    = 1'b0;
      end else if (run) begin
         say_d      = say_q + CW'(1);
         onceki_d   = bit_c;
         herhangi_d = herhangi_n;
         parite_d   = parite_n;
         komsu_d    = komsu_n;
      end

      case (opkod)
         OP_KOMSU:    bayrak = komsu_n;
         OP_HERHANGI: bayrak = herhangi_n;
         OP_CIFT:     bayrak = ~parite_n;
         default:     bayrak = parite_n;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         say_q      <= '0;
         onceki_q   <= 1'b0;
         herhangi_q <= 1'b0;
         parite_q   <= 1'b0;
         komsu_q    <= 1'b0;
      end else begin
         say_q      <= say_d;
         onceki_q   <= onceki_d;
         herhangi_q <= herhangi_d;
         parite_q   <= parite_d;
         komsu_q    <= komsu_d;
      end
   end

endmodule

// File: rtl/bib_seri_alu.sv
// rtl/bib_seri_alu.sv - multi-cycle instruction ALU with bit-serial pattern opcodes
// Owns the BOS/ISLE FSM, the ALU mux and the result/handshake registers.
module bib_seri_alu
   import bib_pkg::*;
#(
   parameter int W = 3
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           basla,
   input  logic [2*W+2:0] buyruk,
   output logic [W:0]     sonuc,
   output logic           bitti,
   output logic           mesgul
);

   durum_t         durum_q, durum_d;
   logic [2*W+2:0] kelime_q, kelime_d;
   logic [W:0]     sonuc_q, sonuc_d;
   logic           bitti_q, bitti_d;
   logic           mesgul_q, mesgul_d;

   logic [2:0]   opkod;
   logic [W-1:0] a_c, b_c;
   logic [W:0]   alu_c;
   logic         tara_basla, tara_calis, tara_son, tara_bayrak;

   assign opkod = kelime_q[2*W+2:2*W];
   assign a_c   = kelime_q[2*W+1:W];
   assign b_c   = kelime_q[W-1:0];

   assign tara_basla = (durum_q == BOS) && basla;
   assign tara_calis = (durum_q == ISLE) && opkod[2];

   bib_tarayici #(.W(W)) u_tarayici (
      .clk    (clk),
      .rst    (rst),
      .start  (tara_basla),
      .run    (tara_calis),
      .alan   (kelime_q[2*W-1:0]),
      .opkod  (opkod),
      .son    (tara_son),
      .bayrak (tara_bayrak)
   );

   // The extra result bit absorbs the add carry and the subtract borrow.
   always_comb begin
      case (opkod)
         OP_TOPLA: alu_c = {1'b0, a_c} + {1'b0, b_c};
         OP_CIKAR: alu_c = {1'b0, a_c} - {1'b0, b_c};
         OP_VE:    alu_c = {1'b0, a_c & b_c};
         default:  alu_c = {1'b0, a_c | b_c};
      endcase
   end

   always_comb begin
      durum_d  = durum_q;
      kelime_d = kelime_q;
      sonuc_d  = sonuc_q;
      bitti_d  = 1'b0;
      mesgul_d = mesgul_q;

      case (durum_q)
         BOS: begin
            if (basla) begin
               kelime_d = buyruk;
               durum_d  = ISLE;
               mesgul_d = 1'b1;
            end
         end
         ISLE: begin
            if (!opkod[2]) begin
               sonuc_d  = alu_c;
               bitti_d  = 1'b1;
               mesgul_d = 1'b0;
               durum_d  = BOS;
            end else if (tara_son) begin
               sonuc_d  = {(W + 1){tara_bayrak}};
               bitti_d  = 1'b1;
               mesgul_d = 1'b0;
               durum_d  = BOS;
            end
         end
         default: durum_d = BOS;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         durum_q  <= BOS;
         kelime_q <= '0;
         sonuc_q  <= '0;
         bitti_q  <= 1'b0;
         mesgul_q <= 1'b0;
      end else begin
         durum_q  <= durum_d;
         kelime_q <= kelime_d;
         sonuc_q  <= sonuc_d;
         bitti_q  <= bitti_d;
         mesgul_q <= mesgul_d;
      end
   end

   assign sonuc  = sonuc_q;
   assign bitti  = bitti_q;
   assign mesgul = mesgul_q;

endmodule

// File: tb/tb_bib_seri_alu.sv
// tb/tb_bib_seri_alu.sv - table-driven scoreboard bench for W=3 and W=4 instances
module tb_bib_seri_alu;

   typedef struct {
      int         done;
      logic [4:0] e;
   } exp_t;

   typedef struct {
      logic [8:0] w;
      logic [3:0] e;
      int         lat;
   } v3_t;

   typedef struct {
      logic [10:0] w;
      logic [4:0]  e;
      int          lat;
   } v4_t;

   logic        clk = 1'b0;
   logic        rst3, rst4;
   logic        basla3, basla4;
   logic [8:0]  buyruk3;
   logic [10:0] buyruk4;
   logic [3:0]  sonuc3;
   logic [4:0]  sonuc4;
   logic        bitti3, bitti4, mesgul3, mesgul4;

   int   cyc = 0;
   int   pass_cnt = 0;
   int   total_cnt = 0;
   exp_t q3[$];
   exp_t q4[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bib_seri_alu #(.W(3)) dut3 (
      .clk(clk), .rst(rst3), .basla(basla3), .buyruk(buyruk3),
      .sonuc(sonuc3), .bitti(bitti3), .mesgul(mesgul3)
   );

   bib_seri_alu #(.W(4)) dut4 (
      .clk(clk), .rst(rst4), .basla(basla4), .buyruk(buyruk4),
      .sonuc(sonuc4), .bitti(bitti4), .mesgul(mesgul4)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   always @(negedge clk) begin
      exp_t t;
      if (bitti3) begin
         if (q3.size() == 0) check("bitti3_unexpected", 32'(bitti3), 32'd0);
         else begin
            t = q3.pop_front();
            check("sonuc3", 32'(sonuc3), 32'(t.e));
            check("bitti3_cycle", cyc, t.done);
         end
      end else if (q3.size() > 0 && q3[0].done < cyc) begin
         t = q3.pop_front();
         check("bitti3_missing", 32'(bitti3), 32'd1);
      end
   end

   always @(negedge clk) begin
      exp_t t;
      if (bitti4) begin
         if (q4.size() == 0) check("bitti4_unexpected", 32'(bitti4), 32'd0);
         else begin
            t = q4.pop_front();
            check("sonuc4", 32'(sonuc4), 32'(t.e));
            check("bitti4_cycle", cyc, t.done);
         end
      end else if (q4.size() > 0 && q4[0].done < cyc) begin
         t = q4.pop_front();
         check("bitti4_missing", 32'(bitti4), 32'd1);
      end
   end

   // Called at a negedge with the DUT idle; returns at the negedge where bitti is visible.
   task automatic issue3(input logic [8:0] w, input logic [3:0] e, input int lat, input bit noisy);
      int done;
      basla3  = 1'b1;
      buyruk3 = w;
      done    = cyc + 1 + lat;
      q3.push_back('{done, {1'b0, e}});
      @(negedge clk);
      basla3 = 1'b0;
      while (cyc < done) begin
         check("mesgul3_busy", 32'(mesgul3), 32'd1);
         if (noisy) begin
            basla3  = 1'($urandom_range(0, 1));
            buyruk3 = 9'($urandom);
         end
         @(negedge clk);
      end
      basla3 = 1'b0;
      check("mesgul3_done", 32'(mesgul3), 32'd0);
   endtask

   task automatic issue4(input logic [10:0] w, input logic [4:0] e, input int lat);
      int done;
      basla4  = 1'b1;
      buyruk4 = w;
      done    = cyc + 1 + lat;
      q4.push_back('{done, e});
      @(negedge clk);
      basla4 = 1'b0;
      while (cyc < done) begin
         check("mesgul4_busy", 32'(mesgul4), 32'd1);
         basla4  = 1'($urandom_range(0, 1));
         buyruk4 = 11'($urandom);
         @(negedge clk);
      end
      basla4 = 1'b0;
      check("mesgul4_done", 32'(mesgul4), 32'd0);
   endtask

   initial begin
      v3_t t3[12];
      v4_t t4[5];

      t3[0]  = '{9'b000_111_111, 4'b1110, 1};
      t3[1]  = '{9'b001_010_101, 4'b1101, 1};
      t3[2]  = '{9'b011_100_001, 4'b0101, 1};
      t3[3]  = '{9'b010_110_011, 4'b0010, 1};
      t3[4]  = '{9'b100_101_010, 4'b0000, 6};
      t3[5]  = '{9'b100_101_011, 4'b1111, 6};
      t3[6]  = '{9'b100_000_000, 4'b1111, 6};
      t3[7]  = '{9'b101_000_000, 4'b0000, 6};
      t3[8]  = '{9'b101_100_000, 4'b1111, 6};
      t3[9]  = '{9'b110_101_100, 4'b0000, 6};
      t3[10] = '{9'b110_000_000, 4'b1111, 6};
      t3[11] = '{9'b111_101_100, 4'b1111, 6};

      t4[0] = '{11'b101_0000_0000, 5'b00000, 8};
      t4[1] = '{11'b000_1111_1111, 5'b11110, 1};
      t4[2] = '{11'b111_0000_0001, 5'b11111, 8};
      t4[3] = '{11'b001_0000_0001, 5'b11111, 1};
      t4[4] = '{11'b100_0110_0000, 5'b11111, 8};

      rst3 = 1'b1; rst4 = 1'b1;
      basla3 = 1'b0; basla4 = 1'b0;
      buyruk3 = '0; buyruk4 = '0;
      repeat (2) @(negedge clk);
      check("rst_sonuc3", 32'(sonuc3), 32'd0);
      check("rst_bitti3", 32'(bitti3), 32'd0);
      check("rst_mesgul3", 32'(mesgul3), 32'd0);
      check("rst_sonuc4", 32'(sonuc4), 32'd0);
      check("rst_mesgul4", 32'(mesgul4), 32'd0);
      rst3 = 1'b0; rst4 = 1'b0;
      @(negedge clk);

      // Back-to-back: each issue starts on the negedge where the previous bitti is high.
      for (int i = 0; i < 12; i++) issue3(t3[i].w, t3[i].e, t3[i].lat, (i % 2) == 1);

      basla3  = 1'b1;
      buyruk3 = 9'b101_000_000;
      @(negedge clk);
      basla3 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_mesgul3", 32'(mesgul3), 32'd1);
      @(posedge clk);
      #1 rst3 = 1'b1;
      #1;
      check("async_rst_sonuc3", 32'(sonuc3), 32'd0);
      check("async_rst_bitti3", 32'(bitti3), 32'd0);
      check("async_rst_mesgul3", 32'(mesgul3), 32'd0);
      @(negedge clk);
      rst3 = 1'b0;
      repeat (8) @(negedge clk);
      issue3(9'b101_000_100, 4'b1111, 6, 1'b0);

      for (int i = 0; i < 5; i++) issue4(t4[i].w, t4[i].e, t4[i].lat);

      repeat (12) @(negedge clk);
      check("q3_drained", q3.size(), 32'd0);
      check("q4_drained", q4.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/bib_seri_alu.md
Name: bib_seri_alu

Overview:
- Parametrised, multi-cycle successor to the team's 3-bit instruction ALU.
- Accepts one instruction word: 3-bit opcode plus two W-bit operands. Computes a (W+1)-bit result and signals completion with a one-cycle `bitti` pulse.
- Arithmetic/logic opcodes finish in one cycle after acceptance. Bit-pattern opcodes scan the 2W-bit operand field serially, one bit per cycle.
- Sits behind the lab controller, which issues `basla` and reads `sonuc`.

Parameters:
- W, 3, operand width in bits (W >= 2). Instruction width is 2W+3; result width is W+1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- basla  input  1  start request; sampled only when idle.
- buyruk  input  2W+3  instruction word:
  - [2W+2:2W] opcode.
  - [2W+1:W] operand A.
  - [W-1:0] operand B.
  - Bit-pattern ops use the field F = buyruk[2W-1:0] (low 2W bits, index 0 = LSB).
- sonuc  output  W+1  result; holds its value until the next completion.
- bitti  output  1  completion pulse, exactly one cycle.
- mesgul  output  1  high while an instruction is in progress.

Behaviour:
- Reset (async, any time): state BOS, sonuc=0, bitti=0, mesgul=0, bit counter=0, scan flags cleared. An in-flight instruction is abandoned with no bitti.
- FSM states: BOS (idle), ISLE (working).
- BOS:
  - basla=1 at a rising edge (acceptance edge E0): latch buyruk, counter<=0, go to ISLE, mesgul<=1.
  - basla=0: stay in BOS.
- ISLE:
  - basla ignored; the latched word is used, and live buyruk changes have no effect.
- ALU opcodes, result written at E1, zero-extended to W+1:
  - 000: A+B.
  - 001: A-B mod 2^(W+1) (two's complement).
  - 010: A&B.
  - 011: A|B.
- Scan opcodes: one bit of F per edge, counter 0..2W-1. The last bit is processed at edge E(2W), and sonuc is written at that edge.
  - 100: all-ones if any adjacent pair F[i]==F[i-1] (i=1..2W-1), else 0. Bit 0 only seeds the "previous bit" register.
  - 101: all-ones if any F bit is 1, else 0.
  - 110: all-ones if popcount(F) is even, else 0.
  - 111: all-ones if popcount(F) is odd, else 0.
  - Parity is computed as a running XOR; no full counter is required.
- Completion edge (E1 for ALU, E(2W) for scan): sonuc updated, bitti<=1, mesgul<=0, state<=BOS.
- The next edge clears bitti.
- Back-to-back: basla high in the cycle bitti is high is accepted, because the state is already BOS. There are no idle gaps.
- The default/unknown opcode is impossible (3-bit field is fully decoded).
- No overflow flag: the W+1 result width absorbs the add carry.

Decomposition:
- Package bib_pkg:
  - opcode localparams OP_TOPLA, OP_CIKAR, OP_VE, OP_VEYA, OP_KOMSU, OP_HERHANGI, OP_CIFT, OP_TEK.
  - state enum {BOS, ISLE}.
- One natural sub-module: bib_tarayici.
  - Bit-serial scanner holding the counter, previous bit, any-one flag, parity flag and adjacency flag.
  - Inputs: the latched F, a start strobe and the opcode.
  - Outputs: a last-bit strobe and the flag result.
- The top level owns the FSM, ALU mux and output registers.

Test Plan:
- W=3, buyruk=000_111_111, basla 1 cycle -> sonuc=4'b1110 and bitti=1 exactly one cycle after acceptance; mesgul high for 1 cycle.
- W=3, buyruk=001_010_101 -> sonuc=4'b1101 (-3 mod 16). Next, buyruk=011_100_001 issued back-to-back in the bitti cycle -> sonuc=4'b0101 one cycle later.
- W=3 adjacency:
  - 100_101_010 (F=101010) -> sonuc=0000, with bitti at 6 cycles after acceptance.
  - 100_101_011 -> 1111.
- W=3 parity:
  - 110_101_100 (three ones) -> 0000.
  - 111_101_100 -> 1111, bitti at E6.
  - Toggling basla and buyruk during ISLE changes neither result nor timing.
- W=3, 101_000_000 started and rst pulsed at E3 -> all outputs 0 immediately, no bitti. A following 101_000_100 -> 1111 at E6.
- W=4 instance:
  - 101_0000_0000 -> 5'b00000 at E8.
  - 000_1111_1111 -> 5'b11110 at E1.
